font_writer: RTL
================

// Module: font_writer
// PURPOSE
//  Write-side controller for the 8 KB dual-port font BRAM. It accepts 16-bit host words,
//  splits them into two byte writes and auto-increments the address pointer. It also runs a
//  hardware fill (clear or pattern) of N bytes. Sits between the register/bus interface and
//  the font BRAM write port. The video fetch logic owns the read port; no arbitration is needed.
// PARAMETERS
//  ADDR_W    13   font byte address width (2^ADDR_W bytes)
//  WORD_W    16   host word width; always 2 x 8-bit font bytes
//  HI_FIRST  1    1: write word[15:8] at ptr, word[7:0] at ptr+1; 0: low byte first
// PORTS
//  clk            in   1        single clock (wr_clk of font BRAM)
//  reset          in   1        synchronous, active-high
//  addr_valid     in   1        load write pointer request
//  addr_ready     out  1        pointer load accepted when addr_valid & addr_ready
//  addr_data      in   ADDR_W   new write pointer value
//  wr_valid       in   1        host word available
//  wr_ready       out  1        word accepted when wr_valid & wr_ready
//  wr_data        in   WORD_W   host word
//  fill_start     in   1        fill request (taken only when fill_ready)
//  fill_ready     out  1        fill request can be accepted
//  fill_count     in   ADDR_W   bytes to fill; 0 means 2^ADDR_W
//  fill_data      in   8        fill byte value
//  busy           out  1        word in flight or fill running
//  ptr            out  ADDR_W   current write pointer (next byte address)
//  font_wr_en     out  1        BRAM write enable (registered)
//  font_wr_addr   out  ADDR_W   BRAM write address (registered)
//  font_wr_data   out  8        BRAM write data (registered)
// BEHAVIOUR
//  Reset (sync): state=IDLE, ptr=0, font_wr_en=0, font_wr_addr=0, font_wr_data=0, busy=0.
//   All readies are 0 while reset is high. A word or fill in progress is dropped; no further writes.
//  States: IDLE, BYTE0, BYTE1, FILL. font_wr_* are registers loaded on the transition into a state.
//  IDLE: wr_ready = ~fill_start; addr_ready = 1; fill_ready = 1.
//   addr accept -> ptr <= addr_data.
//   word accept -> latch word; go BYTE0. The first byte is written at ptr, or at addr_data if
//    a pointer load is accepted in the same cycle (the load applies first).
//   fill accept -> go FILL; remaining <= fill_count (0 => 2^ADDR_W). Fill wins over wr_valid
//    in the same cycle. A same-cycle addr load applies first.
//  BYTE0: font_wr_en=1, first byte at ptr; ptr <= ptr+1; go BYTE1. All readies are 0.
//  BYTE1: font_wr_en=1, second byte at ptr; ptr <= ptr+1. wr_ready=1, addr_ready=0, fill_ready=0.
//   word accept -> BYTE0, so a held wr_valid streams 1 word / 2 cycles. Otherwise -> IDLE.
//  FILL: one byte per cycle: font_wr_en=1, addr=ptr, data=fill_data latched at start;
//   ptr <= ptr+1; remaining-1. Exit to IDLE after the last byte. All readies are 0.
//  Latency: BRAM write occurs in the cycle after a word/fill accept. Font data is readable by the
//   video side one rd_clk later.
//  Pointer arithmetic: modulo 2^ADDR_W; 0x1FFF+1 wraps to 0x0000 silently, both mid-word and mid-fill.
//  busy = (state != IDLE). font_wr_en is 0 in IDLE. font_wr_addr/data hold their last values
//   when font_wr_en=0.
//  Counter widths: remaining is ADDR_W+1 bits so a count of 2^ADDR_W is representable.
// STRUCTURE
//  State encodings and the FONT_ADDR_W constant go in the shared xosera defines include. The
//   video fetch logic uses the same width.
//  Single flat module; no sub-module is natural (FSM + pointer + fill counter only).
// TESTING
//  1. reset; addr 0x0100; word 0xA55A -> two writes: (0x0100,A5) then (0x0101,5A); ptr=0x0102.
//  2. wr_valid held, words 0x1111,0x2222,0x3333 from 0x0200 -> 6 consecutive en cycles,
//     addrs 0x0200..0x0205, data 11,11,22,22,33,33; wr_ready high only in IDLE/BYTE1.
//  3. addr 0x1FFF, word 0x1234 -> (0x1FFF,12), (0x0000,34); ptr=0x0001.
//  4. fill_count=0, fill_data=0x00 from ptr 0 -> 8192 writes, busy high exactly 8192 cycles,
//     ptr back to 0x0000.
//  5. fill_start and wr_valid together in IDLE -> fill runs first, wr_ready=0 during it; word
//     written at end-of-fill ptr.
//  6. reset asserted during fill after 10 bytes -> font_wr_en=0 next cycle, ptr=0, busy=0,
//     no later writes.

Source files
------------

// File: rtl/font_writer_pkg.sv
// Shared definitions for the font BRAM write-side controller: address width
// and the controller state encoding, also used by the video fetch logic.
package font_writer_pkg;

    localparam int FONT_ADDR_W = 13;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BYTE0 = 2'd1,
        ST_BYTE1 = 2'd2,
        ST_FILL  = 2'd3
    } fw_state_t;

endpackage

// File: rtl/font_writer_if.sv
// Host-side port bundle of the font writer: pointer load, word write and fill
// handshakes plus the busy/pointer status returned to the register block.
interface font_writer_if #(
    parameter int ADDR_W = 13,
    parameter int WORD_W = 16
);
    logic              addr_valid;
    logic              addr_ready;
    logic [ADDR_W-1:0] addr_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [WORD_W-1:0] wr_data;
    logic              fill_start;
    logic              fill_ready;
    logic [ADDR_W-1:0] fill_count;
    logic [7:0]        fill_data;
    logic              busy;
    logic [ADDR_W-1:0] ptr;

    modport master (
        output addr_valid, addr_data, wr_valid, wr_data,
               fill_start, fill_count, fill_data,
        input  addr_ready, wr_ready, fill_ready, busy, ptr
    );

    modport slave (
        input  addr_valid, addr_data, wr_valid, wr_data,
               fill_start, fill_count, fill_data,
        output addr_ready, wr_ready, fill_ready, busy, ptr
    );
endinterface

// File: rtl/font_writer.sv
// Font BRAM write-side controller: splits host words into two byte writes with
// an auto-incrementing pointer, and runs hardware fills of N bytes.
module font_writer
    import font_writer_pkg::*;
#(
    parameter int ADDR_W   = FONT_ADDR_W,
    parameter int WORD_W   = 16,
    parameter bit HI_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    font_writer_if.slave      host,
    output logic              font_wr_en,
    output logic [ADDR_W-1:0] font_wr_addr,
    output logic [7:0]        font_wr_data
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(1) << ADDR_W;

    fw_state_t         state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [7:0]        fill_byte_q, fill_byte_d;
    logic [ADDR_W:0]   remaining_q, remaining_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic [ADDR_W-1:0] base_ptr;
    logic              addr_ready_c, wr_ready_c, fill_ready_c;

    function automatic logic [7:0] first_byte(input logic [WORD_W-1:0] w);
        return HI_FIRST ? w[WORD_W-1 -: 8] : w[7:0];
    endfunction

    function automatic logic [7:0] second_byte(input logic [WORD_W-1:0] w);
        return HI_FIRST ? w[7:0] : w[WORD_W-1 -: 8];
    endfunction

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        word_d       = word_q;
        fill_byte_d  = fill_byte_q;
        remaining_d  = remaining_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        base_ptr     = ptr_q;
        addr_ready_c = 1'b0;
        wr_ready_c   = 1'b0;
        fill_ready_c = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                addr_ready_c = 1'b1;
                fill_ready_c = 1'b1;
                wr_ready_c   = ~host.fill_start;
                // A same-cycle pointer load takes effect before the word/fill starts.
                if (host.addr_valid) begin
                    ptr_d    = host.addr_data;
                    base_ptr = host.addr_data;
                end
                if (host.fill_start) begin
                    state_d     = ST_FILL;
                    fill_byte_d = host.fill_data;
                    remaining_d = (host.fill_count == '0) ? FULL_COUNT
                                                          : {1'b0, host.fill_count};
                    wr_en_d     = 1'b1;
                    wr_addr_d   = base_ptr;
                    wr_data_d   = host.fill_data;
                end else if (host.wr_valid) begin
                    state_d   = ST_BYTE0;
                    word_d    = host.wr_data;
                    wr_en_d   = 1'b1;
                    wr_addr_d = base_ptr;
                    wr_data_d = first_byte(host.wr_data);
                end
            end
            ST_BYTE0: begin
                state_d   = ST_BYTE1;
                ptr_d     = ptr_q + ADDR_W'(1);
                wr_en_d   = 1'b1;
                wr_addr_d = ptr_q + ADDR_W'(1);
                wr_data_d = second_byte(word_q);
            end
            ST_BYTE1: begin
                wr_ready_c = 1'b1;
                ptr_d      = ptr_q + ADDR_W'(1);
                // Back-to-back words keep the write port busy every cycle.
                if (host.wr_valid) begin
                    state_d   = ST_BYTE0;
                    word_d    = host.wr_data;
                    wr_en_d   = 1'b1;
                    wr_addr_d = ptr_q + ADDR_W'(1);
                    wr_data_d = first_byte(host.wr_data);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FILL: begin
                ptr_d       = ptr_q + ADDR_W'(1);
                remaining_d = remaining_q - (ADDR_W+1)'(1);
                if (remaining_q == (ADDR_W+1)'(1)) begin
                    state_d = ST_IDLE;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = ptr_q + ADDR_W'(1);
                    wr_data_d = fill_byte_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            word_q      <= '0;
            fill_byte_q <= '0;
            remaining_q <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            word_q      <= word_d;
            fill_byte_q <= fill_byte_d;
            remaining_q <= remaining_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    assign host.addr_ready = addr_ready_c & ~reset;
    assign host.wr_ready   = wr_ready_c & ~reset;
    assign host.fill_ready = fill_ready_c & ~reset;
    assign host.busy       = (state_q != ST_IDLE);
    assign host.ptr        = ptr_q;

    assign font_wr_en   = wr_en_q;
    assign font_wr_addr = wr_addr_q;
    assign font_wr_data = wr_data_q;

endmodule
